// File: rtl/hex_pkg.sv
// Shared definitions for the hex display controller: register offsets,
// CTRL field positions, blank pattern and the active-low segment table.
package hex_pkg;

  localparam int unsigned OFF_DATA = 0;
  localparam int unsigned OFF_CTRL = 4;
  localparam int unsigned OFF_DIV  = 8;

  localparam int unsigned CTRL_EN_LSB    = 0;
  localparam int unsigned CTRL_BLINK_LSB = 8;
  localparam int unsigned CTRL_BLINK_ON  = 16;

  localparam logic [6:0] BLANK = 7'h7F;

  // gfedcba, active-low; entry 15 first so that SEG_TABLE[n] decodes nibble n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_CTRL,
    REG_DIV
  } reg_sel_e;

  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_decode
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_of(nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped N-digit hex seven-segment display with per-digit enable,
// per-digit blinking from a programmable prescaler, and full register readback.
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int unsigned      BITS        = 32,
  parameter logic [BITS-1:0]  BASE        = 32'hF000_0000,
  parameter int unsigned      DIGITS      = 4,
  parameter logic [BITS-1:0]  RESET_VAL   = 32'h0000_DEAD,
  parameter logic [BITS-1:0]  DEFAULT_DIV = 32'd25_000_000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [BITS-1:0]     ABUS,
  inout  logic [BITS-1:0]     DBUS,
  input  logic                WE,
  input  logic                FLUSH,
  output logic [7*DIGITS-1:0] HEX
);

  localparam int unsigned NW = 4 * DIGITS;

  localparam logic [BITS-1:0] ADDR_DATA = BASE + BITS'(OFF_DATA);
  localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(OFF_CTRL);
  localparam logic [BITS-1:0] ADDR_DIV  = BASE + BITS'(OFF_DIV);

  function automatic logic [7*DIGITS-1:0] reset_hex();
    logic [7*DIGITS-1:0] h;
    h = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      h[7*i +: 7] = seg_of(RESET_VAL[4*i +: 4]);
    end
    return h;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RESET = reset_hex();

  reg_sel_e            sel;
  logic                div_wr;
  logic [BITS-1:0]     rd_data;

  logic [NW-1:0]       data_q;
  logic [DIGITS-1:0]   en_q;
  logic [DIGITS-1:0]   blink_q;
  logic                blink_on_q;
  logic [BITS-1:0]     div_q;
  logic [BITS-1:0]     cnt_q;
  logic                phase_q;
  logic [7*DIGITS-1:0] hex_d;
  logic [7*DIGITS-1:0] hex_q;

  // FLUSH suppresses every select, so it blocks both writes and bus drive
  always_comb begin
    sel = REG_NONE;
    if (!FLUSH) begin
      if (ABUS == ADDR_DATA)      sel = REG_DATA;
      else if (ABUS == ADDR_CTRL) sel = REG_CTRL;
      else if (ABUS == ADDR_DIV)  sel = REG_DIV;
    end
  end

  assign div_wr = WE && (sel == REG_DIV);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q     <= RESET_VAL[NW-1:0];
      en_q       <= '1;
      blink_q    <= '0;
      blink_on_q <= 1'b0;
      div_q      <= DEFAULT_DIV;
    end else if (WE) begin
      case (sel)
        REG_DATA: data_q <= DBUS[NW-1:0];
        REG_CTRL: begin
          en_q       <= DBUS[CTRL_EN_LSB +: DIGITS];
          blink_q    <= DBUS[CTRL_BLINK_LSB +: DIGITS];
          blink_on_q <= DBUS[CTRL_BLINK_ON];
        end
        REG_DIV:  div_q <= DBUS;
        default:  ;
      endcase
    end
  end

  // Any DIV write restarts the half-period from the new value, taking
  // priority over an expiry that lands on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= DEFAULT_DIV;
      phase_q <= 1'b0;
    end else if (div_wr) begin
      cnt_q   <= DBUS;
      phase_q <= 1'b0;
    end else if (div_q == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q   <= div_q;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q - BITS'(1);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [6:0] seg;
    logic       vis;

    seg7_decode u_dec (
      .nibble (data_q[4*i +: 4]),
      .seg    (seg)
    );

    assign vis               = en_q[i] && !(blink_on_q && blink_q[i] && phase_q);
    assign hex_d[7*i +: 7]   = vis ? seg : BLANK;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) hex_q <= HEX_RESET;
    else       hex_q <= hex_d;
  end

  assign HEX = hex_q;

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_DATA: rd_data[NW-1:0] = data_q;
      REG_CTRL: begin
        rd_data[CTRL_EN_LSB +: DIGITS]    = en_q;
        rd_data[CTRL_BLINK_LSB +: DIGITS] = blink_q;
        rd_data[CTRL_BLINK_ON]            = blink_on_q;
      end
      REG_DIV:  rd_data = div_q;
      default:  ;
    endcase
  end

  assign DBUS = ((sel != REG_NONE) && !WE) ? rd_data : 'z;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: the driver predicts HEX and read data
// from an elapsed-time reference model; a negedge monitor pops and compares.
module tb_hex_display_ctrl;

  localparam logic [31:0] BASE     = 32'hF000_0000;
  localparam logic [31:0] RVAL     = 32'h0000_DEAD;
  localparam logic [31:0] DDIV     = 32'd6;
  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        we     = 1'b0;
  logic        flush  = 1'b0;
  logic        drv_en = 1'b0;
  logic [31:0] abus   = '0;
  logic [31:0] wdata  = '0;
  wire  [31:0] dbus;
  logic [27:0] hex;

  assign dbus = drv_en ? wdata : 'z;

  // pull-ups make a released bus read as all ones
  for (genvar b = 0; b < 32; b++) begin : g_pull
    pullup (dbus[b]);
  end

  hex_display_ctrl #(
    .BITS        (32),
    .BASE        (BASE),
    .DIGITS      (4),
    .RESET_VAL   (RVAL),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .ABUS  (abus),
    .DBUS  (dbus),
    .WE    (we),
    .FLUSH (flush),
    .HEX   (hex)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_data;
  logic [3:0]  m_en;
  logic [3:0]  m_blink;
  logic        m_bon;
  logic [31:0] m_div;
  int          edge_n = 0;
  int          origin = 0;

  logic [27:0] hexq [$];
  logic [31:0] rdq  [$];
  string       rdname [$];
  logic        rd_chk = 1'b0;

  int errors = 0;
  int checks = 0;

  // Phase after edge k: number of whole DIV+1 periods since the last load, mod 2.
  function automatic logic m_phase(int k);
    if (m_div == 0 || k < origin) return 1'b0;
    return ((k - origin) / (int'(m_div) + 1)) % 2 == 1;
  endfunction

  function automatic logic [27:0] m_hex(int k);
    logic [27:0] h;
    logic        ph;
    ph = m_phase(k);
    for (int i = 0; i < 4; i++) begin
      if (m_en[i] && !(m_bon && m_blink[i] && ph)) h[7*i +: 7] = seg_ref[m_data[4*i +: 4]];
      else                                         h[7*i +: 7] = 7'h7F;
    end
    return h;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a == BASE)          return {16'h0, m_data};
    if (a == BASE + 32'd4)  return {15'h0, m_bon, 4'h0, m_blink, 4'h0, m_en};
    if (a == BASE + 32'd8)  return m_div;
    return RELEASED;
  endfunction

  task automatic model_reset();
    m_data  = RVAL[15:0];
    m_en    = 4'hF;
    m_blink = 4'h0;
    m_bon   = 1'b0;
    m_div   = DDIV;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    hexq.push_back(m_hex(edge_n - 1));
    if (rst) origin = edge_n;
    else if (we && !flush) begin
      if (abus == BASE) m_data = wdata[15:0];
      else if (abus == BASE + 32'd4) begin
        m_en    = wdata[3:0];
        m_blink = wdata[11:8];
        m_bon   = wdata[16];
      end else if (abus == BASE + 32'd8) begin
        m_div  = wdata;
        origin = edge_n;
      end
    end
    we = 1'b0; drv_en = 1'b0; flush = 1'b0; rd_chk = 1'b0; abus = '0;
  endtask

  task automatic reset_edge(bit mid);
    @(posedge clk);
    #1;
    edge_n++;
    if (mid) begin
      #1;
      rst = 1'b1;
    end
    model_reset();
    origin = edge_n;
    hexq.push_back(m_hex(edge_n));
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, bit fl);
    abus = a; wdata = d; drv_en = 1'b1; we = 1'b1; flush = fl;
    step();
  endtask

  task automatic rd(logic [31:0] a, bit fl, string nm);
    abus = a; we = 1'b0; flush = fl; drv_en = 1'b0;
    rdq.push_back(fl ? RELEASED : m_read(a));
    rdname.push_back(nm);
    rd_chk = 1'b1;
    step();
  endtask

  always @(negedge clk) begin
    logic [27:0] eh;
    logic [31:0] ed;
    string       nm;
    if (hexq.size() > 0) begin
      eh = hexq.pop_front();
      checks++;
      if (hex !== eh) begin
        errors++;
        $display("FAIL hex t=%0t got=%h want=%h", $time, hex, eh);
      end
    end
    if (rd_chk) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rd_queue t=%0t got=%h want=<queued value>", $time, dbus);
      end else begin
        ed = rdq.pop_front();
        nm = rdname.pop_front();
        if (dbus !== ed) begin
          errors++;
          $display("FAIL %s t=%0t got=%h want=%h", nm, $time, dbus, ed);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op;
    logic [31:0] a;

    reset_edge(1'b0);
    reset_edge(1'b0);
    rst = 1'b0;

    rd(BASE + 32'd4, 1'b0, "ctrl_reset");
    rd(BASE + 32'd8, 1'b0, "div_reset");
    rd(BASE,         1'b0, "data_reset");
    rd(32'h0,        1'b0, "idle_release");

    wr(BASE, 32'h0000_1234, 1'b0);
    step();
    rd(BASE, 1'b0, "data_1234");

    wr(BASE + 32'd4, 32'h0000_0005, 1'b0);
    step();
    rd(BASE + 32'd4, 1'b0, "ctrl_5");

    wr(BASE + 32'd8, 32'd3, 1'b0);
    wr(BASE + 32'd4, 32'h0001_010F, 1'b0);
    repeat (12) step();
    wr(BASE + 32'd8, 32'd0, 1'b0);
    repeat (5) step();

    wr(BASE, 32'h0000_ABCD, 1'b1);
    rd(BASE, 1'b1, "flush_read");
    rd(BASE, 1'b0, "data_after_flush");
    wr(BASE + 32'd12, 32'hFFFF_FFFF, 1'b0);
    rd(BASE,         1'b0, "data_after_bad");
    rd(BASE + 32'd4, 1'b0, "ctrl_after_bad");
    rd(BASE + 32'd8, 1'b0, "div_after_bad");
    rd(BASE + 32'd12, 1'b0, "bad_addr_read");

    wr(BASE + 32'd8, 32'd2, 1'b0);
    wr(BASE + 32'd4, 32'h0001_0F0F, 1'b0);
    repeat (5) step();
    reset_edge(1'b1);
    rd(BASE + 32'd4, 1'b0, "ctrl_in_reset");
    rd(32'h0,        1'b0, "idle_in_reset");
    rst = 1'b0;
    wr(BASE + 32'd4, 32'h0001_0F0F, 1'b0);
    repeat (20) step();

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: wr(BASE, $urandom, 1'b0);
        1: wr(BASE + 32'd4, $urandom, 1'b0);
        2: wr(BASE + 32'd8, 32'($urandom_range(0, 5)), 1'b0);
        3: begin
          a = BASE + 32'(4 * $urandom_range(0, 2));
          rd(a, 1'b0, "rand_read");
        end
        4: begin
          a = BASE + 32'(4 * $urandom_range(0, 2));
          wr(a, $urandom, 1'b1);
        end
        5: begin
          a = BASE + 32'(4 * $urandom_range(0, 2));
          rd(a, 1'b1, "rand_flush_read");
        end
        6: wr(BASE + 32'(4 * $urandom_range(3, 7)), $urandom, 1'b0);
        default: repeat ($urandom_range(1, 4)) step();
      endcase
    end

    step();
    @(negedge clk);
    #1;
    checks++;
    if (hexq.size() != 0 || rdq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got=%0d/%0d want=0/0", hexq.size(), rdq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
